str_match_counter: RTL and testbench

//  Parametrised, runtime-programmable successor to the fixed "Welcom" string finder.

---
 rtl/str_match_pkg.sv | 18 +
 rtl/char_window.sv | 51 +++++
 rtl/str_match_counter.sv | 133 +++++++++++++
 tb/tb_str_match_counter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/str_match_pkg.sv
// Shared sizing helpers and default pattern for the programmable string matcher.
package str_match_pkg;

  // Width needed to hold a pattern length 0..max_len.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Width needed to index one pattern character 0..max_len-1.
  function automatic int addr_w(input int max_len);
    return $clog2(max_len);
  endfunction

  // The pattern the original fixed-function finder looked for.
  localparam int                        DEFAULT_LEN = 6;
  localparam logic [8*DEFAULT_LEN-1:0]  DEFAULT_PAT = "Welcom";

endpackage

// File: rtl/char_window.sv
// History window for the matcher: shift register of past characters
// (newest at hist[0]) plus a saturating count of valid entries.
module char_window
  import str_match_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_LEN = 8,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             shift,
  input  logic                             flush,
  input  logic [DATA_W-1:0]                din,
  output logic [MAX_LEN-1:0][DATA_W-1:0]   hist,
  output logic [LEN_W-1:0]                 fill
);

  logic [MAX_LEN-1:0][DATA_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]               fill_q, fill_d;

  // Next window: flush empties it, otherwise a shift pushes din in at the newest end.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (flush) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift) begin
      hist_d = {hist_q[MAX_LEN-2:0], din};
      if (fill_q != LEN_W'(MAX_LEN)) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // Window state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

  assign hist = hist_q;
  assign fill = fill_q;

endmodule

// File: rtl/str_match_counter.sv
// Runtime-programmable string matcher: compares the newest len characters of
// the stream against a configured pattern and counts matches.
module str_match_counter
  import str_match_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 4,
  localparam int LEN_W   = len_w(MAX_LEN),
  localparam int ADDR_W  = addr_w(MAX_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dv,
  input  logic [DATA_W-1:0] data,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_char,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              overlap_en,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  num,
  output logic              get_flag,
  output logic              cnt_sat
);

  logic [MAX_LEN-1:0][DATA_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic [CNT_W-1:0]               num_q, num_d;
  logic                           flag_q, flag_d;
  logic                           sat_q, sat_d;

  logic [MAX_LEN-1:0][DATA_W-1:0] hist;
  logic [LEN_W-1:0]               fill;
  logic [DATA_W-1:0]              cand [MAX_LEN];
  logic [ADDR_W-1:0]              pidx;
  logic                           win_eq;
  logic                           len_ok;
  logic                           fill_ok;
  logic                           match;
  logic                           win_shift;
  logic                           win_flush;

  // The oldest history entry keeps the window MAX_LEN deep but a len-long
  // compare only ever reaches back len-1 entries behind the incoming char.
  logic unused_oldest;
  assign unused_oldest = ^hist[MAX_LEN-1];

  // A config write discards any coincident beat; a non-overlapping match
  // restarts the window so the next match needs len fresh characters.
  assign win_shift = dv & ~cfg_we;
  assign win_flush = cfg_we | (match & ~overlap_en);

  char_window #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) u_window (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (win_shift),
    .flush (win_flush),
    .din   (data),
    .hist  (hist),
    .fill  (fill)
  );

  assign len_ok  = (len_q != '0) && (len_q <= LEN_W'(MAX_LEN));
  assign fill_ok = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);

  // Full-window compare: candidate k (0 = incoming char) must equal pat[len-1-k].
  always_comb begin
    cand[0] = data;
    for (int k = 1; k < MAX_LEN; k++) begin
      cand[k] = hist[k-1];
    end
    win_eq = 1'b1;
    pidx   = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if (LEN_W'(k) < len_q) begin
        pidx = ADDR_W'(len_q - LEN_W'(k) - LEN_W'(1));
        if (cand[k] != pat_q[pidx]) begin
          win_eq = 1'b0;
        end
      end
    end
  end

  assign match = dv & ~cfg_we & len_ok & fill_ok & win_eq;

  // Pattern character and length registers.
  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    if (cfg_we) begin
      pat_d[cfg_addr] = cfg_char;
      len_d           = cfg_len;
    end
  end

  // Saturating counter; clear beats a coincident match but the pulse still fires.
  always_comb begin
    num_d = num_q;
    if (cnt_clr) begin
      num_d = '0;
    end else if (match && (num_q != '1)) begin
      num_d = num_q + CNT_W'(1);
    end
    flag_d = match;
    sat_d  = (num_d == '1);
  end

  // Config, counter and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q  <= '0;
      len_q  <= '0;
      num_q  <= '0;
      flag_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      num_q  <= num_d;
      flag_q <= flag_d;
      sat_q  <= sat_d;
    end
  end

  assign num      = num_q;
  assign get_flag = flag_q;
  assign cnt_sat  = sat_q;

endmodule

// File: tb/tb_str_match_counter.sv
// Bench for str_match_counter: a string-buffer reference model pushes the
// expected {get_flag, cnt_sat, num} per driven cycle; each scenario drains
// the expected and observed queues and compares them.
module tb_str_match_counter;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int NMAX    = (1 << CNT_W) - 1;

  typedef logic [CNT_W+1:0] sb_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dv = 1'b0;
  logic [7:0]        data = '0;
  logic              cfg_we = 1'b0;
  logic [2:0]        cfg_addr = '0;
  logic [7:0]        cfg_char = '0;
  logic [3:0]        cfg_len = '0;
  logic              overlap_en = 1'b0;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  num;
  logic              get_flag;
  logic              cnt_sat;

  int checks = 0;
  int errors = 0;

  sb_t        exp_q[$];
  sb_t        obs_q[$];
  logic [7:0] m_pat [MAX_LEN];
  int         m_len;
  logic [7:0] m_buf[$];
  int         m_num;

  str_match_counter #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dv         (dv),
    .data       (data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_char   (cfg_char),
    .cfg_len    (cfg_len),
    .overlap_en (overlap_en),
    .cnt_clr    (cnt_clr),
    .num        (num),
    .get_flag   (get_flag),
    .cnt_sat    (cnt_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < MAX_LEN; i++) m_pat[i] = 8'h00;
    m_len = 0;
    m_buf.delete();
    m_num = 0;
  endtask

  // Drive one clock cycle, predict its outcome, and record what the DUT shows after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic we,
                       input int addr, input logic [7:0] ch, input int len, input logic clr);
    logic m;
    logic [7:0] c;
    int n;
    dv = v; data = d; cfg_we = we; cfg_char = ch; cnt_clr = clr;
    cfg_addr = addr[2:0];
    cfg_len  = len[3:0];
    m = 1'b0;
    n = m_buf.size();
    if (v && !we && m_len >= 1 && m_len <= MAX_LEN && n + 1 >= m_len) begin
      m = 1'b1;
      for (int k = 0; k < m_len; k++) begin
        c = (k == 0) ? d : m_buf[n-k];
        if (c != m_pat[m_len-1-k]) m = 1'b0;
      end
    end
    if (we) begin
      m_pat[addr] = ch;
      m_len = len;
      m_buf.delete();
    end else if (v) begin
      if (m && !overlap_en) m_buf.delete();
      else begin
        m_buf.push_back(d);
        if (m_buf.size() > MAX_LEN) void'(m_buf.pop_front());
      end
    end
    if (clr) m_num = 0;
    else if (m && m_num < NMAX) m_num++;
    exp_q.push_back({m, (m_num == NMAX), m_num[CNT_W-1:0]});
    @(posedge clk);
    #1;
    obs_q.push_back({get_flag, cnt_sat, num});
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i], 1'b0, 0, 8'h00, 0, 1'b0);
  endtask

  task automatic program_pat(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b0, 8'h00, 1'b1, i, s[i], s.len(), 1'b0);
  endtask

  task automatic clear_cnt();
    cycle(1'b0, 8'h00, 1'b0, 0, 8'h00, 0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++; if (num !== '0) begin errors++; $display("FAIL reset_num: got %0d required 0", num); end
    checks++; if (get_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %b required 0", get_flag); end
    checks++; if (cnt_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b required 0", cnt_sat); end
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    sb_t e, o;
    int nflag = 0;
    overlap_en = 1'b1;
    program_pat("Welcom");
    send("xxWelcomyy");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL basic_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 1) begin errors++; $display("FAIL basic_flags: got %0d required 1", nflag); end
    checks++; if (o[CNT_W-1:0] !== 2'd1) begin errors++; $display("FAIL basic_num: got %0d required 1", o[CNT_W-1:0]); end
  endtask

  task automatic test_restart();
    sb_t e, o;
    int nflag = 0;
    overlap_en = 1'b0;
    clear_cnt();
    send("WWelcom");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL restart_sb: got %b required %b", o, e); end
    end
    checks++; if (o[CNT_W-1:0] !== 2'd1 || nflag != 1) begin errors++; $display("FAIL restart_num: got %0d/%0d required 1/1", o[CNT_W-1:0], nflag); end
    clear_cnt();
    send("Welcoxm");
    nflag = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL broken_sb: got %b required %b", o, e); end
    end
    checks++; if (o[CNT_W-1:0] !== 2'd0 || nflag != 0) begin errors++; $display("FAIL broken_num: got %0d/%0d required 0/0", o[CNT_W-1:0], nflag); end
  endtask

  task automatic test_overlap();
    sb_t e, o;
    overlap_en = 1'b1;
    clear_cnt();
    program_pat("aa");
    send("aaaa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL overlap_sb: got %b required %b", o, e); end
    end
    checks++; if (o[CNT_W-1:0] !== 2'd3) begin errors++; $display("FAIL overlap_num: got %0d required 3", o[CNT_W-1:0]); end
    overlap_en = 1'b0;
    clear_cnt();
    program_pat("aa");
    send("aaaa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL nooverlap_sb: got %b required %b", o, e); end
    end
    checks++; if (o[CNT_W-1:0] !== 2'd2) begin errors++; $display("FAIL nooverlap_num: got %0d required 2", o[CNT_W-1:0]); end
  endtask

  task automatic test_saturate();
    sb_t e, o;
    int nflag = 0;
    overlap_en = 1'b0;
    clear_cnt();
    program_pat("aa");
    send("aaaaaaaaaa");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL sat_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 5) begin errors++; $display("FAIL sat_flags: got %0d required 5", nflag); end
    checks++; if (o[CNT_W-1:0] !== 2'd3 || o[CNT_W] !== 1'b1) begin errors++; $display("FAIL sat_num: got %0d sat %b required 3 sat 1", o[CNT_W-1:0], o[CNT_W]); end
    send("a");
    cycle(1'b1, "a", 1'b0, 0, 8'h00, 0, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL clrmatch_sb: got %b required %b", o, e); end
    end
    checks++; if (o !== {1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL clrmatch: got %b required 1000", o); end
  endtask

  task automatic test_cfg_mid();
    sb_t e, o;
    int nflag = 0;
    overlap_en = 1'b1;
    clear_cnt();
    program_pat("Welcom");
    send("Welc");
    cycle(1'b1, "o", 1'b1, 0, "W", 6, 1'b0);
    send("om");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL cfgmid_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 0) begin errors++; $display("FAIL cfgmid_flags: got %0d required 0", nflag); end
    send("Welcom");
    cycle(1'b0, 8'h00, 1'b1, 0, "W", 0, 1'b0);
    send("Welcom");
    cycle(1'b0, 8'h00, 1'b1, 0, "W", 9, 1'b0);
    send("Welcom");
    nflag = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL lencfg_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 1 || o[CNT_W-1:0] !== 2'd1) begin errors++; $display("FAIL lencfg: got %0d flags num %0d required 1 flag num 1", nflag, o[CNT_W-1:0]); end
  endtask

  task automatic test_reset_mid();
    sb_t e, o;
    int nflag = 0;
    overlap_en = 1'b1;
    clear_cnt();
    program_pat("Welcom");
    send("WelcomWelc");
    dv = 1'b0; cfg_we = 1'b0; cnt_clr = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++; if (num !== '0 || get_flag !== 1'b0 || cnt_sat !== 1'b0) begin errors++; $display("FAIL midreset: got num %0d flag %b sat %b required 0 0 0", num, get_flag, cnt_sat); end
    exp_q.delete(); obs_q.delete();
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send("om");
    send("Welcom");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL postreset_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 0 || o[CNT_W-1:0] !== 2'd0) begin errors++; $display("FAIL postreset: got %0d flags num %0d required 0 0", nflag, o[CNT_W-1:0]); end
  endtask

  task automatic test_gaps();
    sb_t e, o;
    int nflag = 0;
    string s = "Welcom";
    overlap_en = 1'b0;
    program_pat("Welcom");
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i], 1'b0, 0, 8'h00, 0, 1'b0);
      for (int g = 0; g < (i % 3) + 1; g++) cycle(1'b0, "m", 1'b0, 0, 8'h00, 0, 1'b0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o[CNT_W+1]) nflag++;
      if (o !== e) begin errors++; $display("FAIL gaps_sb: got %b required %b", o, e); end
    end
    checks++; if (nflag != 1 || o[CNT_W-1:0] !== 2'd1) begin errors++; $display("FAIL gaps: got %0d flags num %0d required 1 1", nflag, o[CNT_W-1:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart();
    test_overlap();
    test_saturate();
    test_cfg_mid();
    test_reset_mid();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
